// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared FSM states, lock limit and port pick for memory_arbiter
//
// Purpose : common definitions for the two-port memory_bus arbiter.
//   state_t     : IDLE=2'd0, ACCESS=2'd1, DONE=2'd2
//   LOCK_MAX    : maximum consecutive locked accesses before a forced IDLE
//   LOCK_W      : width of the locked-access counter (holds LOCK_MAX)
//   pick_port() : winner selection for the IDLE arbitration slot
// Ports   : none (package)

package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int LOCK_MAX = 16;
  localparam int LOCK_W   = 5;

  // Returns the port to grant. A lone requester always wins. On a tie the
  // port not granted last wins when round-robin is on, or when a lock run
  // was just cut short (yield); otherwise port 0 wins.
  function automatic logic pick_port(
    input logic r0,
    input logic r1,
    input logic last,
    input logic rr,
    input logic yield
  );
    logic win;
    win = 1'b0;
    if (r1 && !r0) begin
      win = 1'b1;
    end else if (r0 && r1 && (rr || yield)) begin
      win = ~last;
    end
    return win;
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-port arbiter in front of memory_bus (CPU port 0, DMA/SPI port 1)
//
// Purpose : grants the single memory_bus port to one requester at a time.
//   Sequence per access: arbitrate (IDLE), drive bus for ACCESS_CYCLES clocks
//   (ACCESS), pulse ack for one clock (DONE). A locked port may chain accesses
//   DONE->ACCESS without re-arbitration, up to LOCK_MAX in a row.
// Build option : ARB_ROUND_ROBIN_EN
//   defined   -> ties go to the port not granted last
//   undefined -> fixed priority, port 0 wins ties
// Parameters :
//   ACCESS_CYCLES  clocks the bus is driven per access (>= 1)
// Ports :
//   clk, reset            clock; synchronous active-high reset
//   req0/req1             request, held until ack
//   addr0/addr1 [15:0]    request address
//   wdata0/wdata1 [15:0]  write data
//   we0/we1               1 = write, 0 = read
//   lock0/lock1           keep grant after ack for back-to-back access
//   ack0/ack1             one-clock completion pulse
//   rdata0/rdata1 [15:0]  read data, valid with ack, held until next ack
//   bus_address [15:0]    to memory_bus address
//   bus_data_in [15:0]    to memory_bus data_in
//   bus_data_out [15:0]   from memory_bus data_out
//   bus_enable            high during ACCESS
//   bus_write_en          high during ACCESS for writes
//   grant                 current / last granted port

module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic        we0,
  input  logic        we1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [15:0] bus_address,
  output logic [15:0] bus_data_in,
  input  logic [15:0] bus_data_out,
  output logic        bus_enable,
  output logic        bus_write_en,
  output logic        grant
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic ROUND_ROBIN = 1'b1;
`else
  localparam logic ROUND_ROBIN = 1'b0;
`endif

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [LOCK_W-1:0] lock_cnt, lock_cnt_d;
  logic              yield, yield_d;
  logic              we_q;

  logic              load;       // sample the chosen port's request onto the bus
  logic              load_port;
  logic              capture;    // latch bus_data_out into rdata[grant]
  logic              lock_g;
  logic              req_g;

  assign lock_g = grant ? lock1 : lock0;
  assign req_g  = grant ? req1  : req0;

  // Next-state and control decode.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    lock_cnt_d = lock_cnt;
    yield_d    = yield;
    load       = 1'b0;
    load_port  = grant;
    capture    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          load       = 1'b1;
          load_port  = pick_port(req0, req1, grant, ROUND_ROBIN, yield);
          cnt_d      = CNT_LOAD;
          lock_cnt_d = LOCK_W'(1);
          yield_d    = 1'b0;
          state_d    = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (cnt == '0) begin
          capture = ~we_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (lock_g && req_g) begin
          if (lock_cnt < LOCK_W'(LOCK_MAX)) begin
            load       = 1'b1;
            load_port  = grant;
            cnt_d      = CNT_LOAD;
            lock_cnt_d = lock_cnt + 1'b1;
            state_d    = ST_ACCESS;
          end else begin
            // Lock run exhausted: the next IDLE slot favours the other port
            // even under fixed priority, otherwise it could never get in.
            yield_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lock_cnt <= '0;
      yield    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      lock_cnt <= lock_cnt_d;
      yield    <= yield_d;
    end
  end

  // Request sampling and read-data capture. Bus outputs only change on a
  // load edge, so they hold steady through ACCESS and DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant       <= 1'b0;
      we_q        <= 1'b0;
      bus_address <= '0;
      bus_data_in <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      if (load) begin
        grant       <= load_port;
        we_q        <= load_port ? we1    : we0;
        bus_address <= load_port ? addr1  : addr0;
        bus_data_in <= load_port ? wdata1 : wdata0;
      end
      if (capture) begin
        if (grant) begin
          rdata1 <= bus_data_out;
        end else begin
          rdata0 <= bus_data_out;
        end
      end
    end
  end

  assign bus_enable   = (state == ST_ACCESS);
  assign bus_write_en = (state == ST_ACCESS) && we_q;
  assign ack0         = (state == ST_DONE) && !grant;
  assign ack1         = (state == ST_DONE) &&  grant;

endmodule
